aes_key_sched_ctrl: RTL and testbench
=====================================

// Module: aes_key_sched_ctrl
// PURPOSE
//  Iterative AES-128 key-schedule sequencer: accepts a 128-bit cipher key over a valid/ready
//  handshake and generates round keys 0..10 at one round per clock, using one shared
//  RotWord/SubWord/Rcon datapath. Round keys are held in an 11-entry store. The cipher
//  core reads them through a random-access port with a per-entry hit flag, so encryption
//  can start before expansion completes.
// PARAMETERS
//  NR       10  number of rounds; only 10 (AES-128) is supported; round-key store has NR+1 entries
//  ADDR_W    4  width of rk_rd_addr
// PORTS
//  clk          in   1       clock; all state changes on its rising edge
//  rst_n        in   1       synchronous, active-low reset
//  key_in       in   128     cipher key; w0 = key_in[127:96]
//  key_valid    in   1       key_in valid
//  key_ready    out  1       block can accept key_in
//  abort        in   1       cancel expansion, invalidate all round keys
//  rk_rd_addr   in   ADDR_W  round-key index 0..10
//  rk_rd_data   out  128     round key at rk_rd_addr (combinational read)
//  rk_rd_hit    out  1       entry rk_rd_addr has been generated for the current key
//  busy         out  1       expansion in progress
//  keys_valid   out  1       all 11 round keys valid
//  done_pulse   out  1       one-cycle pulse when round key 10 becomes valid
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, valid mask 0, round counter 0, store unchanged;
//    key_ready=1, busy=0, keys_valid=0, done_pulse=0, rk_rd_hit=0.
//  - FSM IDLE -> EXPAND on accept; EXPAND -> DONE after round 10 written;
//    DONE -> EXPAND on new accept; any state -> IDLE on abort.
//  - key_ready = (state != EXPAND) && !abort. Accept = key_valid && key_ready.
//  - Accept edge E0: store[0] <= key_in, mask <= 11'b1, rnd <= 1, state EXPAND.
//  - EXPAND, edge Er (r=1..10): store[r] <= next(store[r-1], Rcon[r]), mask[r] <= 1, rnd++.
//    next: t = SubWord(RotWord(w3)) ^ Rcon; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
//    Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (top byte, lower 24 bits zero).
//  - At E10: state DONE; done_pulse=1 for exactly the following cycle.
//  - Latency: key 0 readable the cycle after E0; key r readable the cycle after Er;
//    keys_valid rises 10 cycles after the accept cycle.
//  - busy = (state == EXPAND). keys_valid = (state == DONE).
//  - rk_rd_hit = mask[rk_rd_addr] for addr <= 10. For addr 11..15, hit=0 and rk_rd_data=0.
//    rk_rd_data for a non-hit in-range entry is don't-care; the consumer ignores it.
//  - S-box is an internal synthesizable constant function/case table. No file loading.
//  - abort: at the edge it is seen, state IDLE, mask 0, rnd 0. abort has priority over
//    key_valid in the same cycle, so the key is not accepted. No done_pulse is issued.
//  - New key accepted in DONE: mask <= 11'b1 at the same edge, so old keys 1..10 stop hitting.
//  - rst_n low mid-expansion: same result as abort. The partial store contents are left
//    as-is, but none of them hit.
//  - key_valid held with key_ready=0: ignored; the source must hold key_in stable until accepted.
// CONFIGURATION
//  AES_KEY_ZEROIZE_EN defined:
//    - abort, reset and every new accept also clear store[1..10] to 0 at that edge.
//    - rk_rd_data is forced to 0 whenever rk_rd_hit=0.
//  Not defined:
//    - store is never cleared.
//    - non-hit rk_rd_data is don't-care.
// TESTING
//  1 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c accepted at E0:
//    - rk1 = a0fafe1788542cb123a339392a6c7605, readable after E1.
//    - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, readable after E10.
//    - done_pulse high exactly 1 cycle; keys_valid=1.
//  2 Progressive hit: with addr=5, rk_rd_hit=0 through E4 and 1 from the cycle after E5.
//    With addr=12, hit stays 0 and data=0 throughout.
//  3 abort asserted after E6 together with key_valid=1:
//    - key not accepted; next cycle busy=0, hit=0 for all addr.
//    - no done_pulse; key_ready=1 once abort drops.
//  4 Back-to-back: in DONE, accept all-zero key:
//    - rk0 hits immediately; rk1..10 stop hitting until regenerated.
//    - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
//  5 rst_n=0 for one cycle mid-expansion (after E3):
//    - all outputs at reset values; expansion does not resume.
//    - a re-sent key_valid is accepted.
//  6 AES_KEY_ZEROIZE_EN build: after abort, rk_rd_data=0 for addr 0..15 and
//    store[1..10] reads 0 after the next accept until rewritten.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule sequencer: one round key per clock into an 11-entry store.
// Optional build macro AES_KEY_ZEROIZE_EN clears stale round keys and masks non-hit reads.
`timescale 1ns/1ps
module aes_key_sched_ctrl #(
  parameter int NR     = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [127:0]      key_in,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic              abort,
  input  logic [ADDR_W-1:0] rk_rd_addr,
  output logic [127:0]      rk_rd_data,
  output logic              rk_rd_hit,
  output logic              busy,
  output logic              keys_valid,
  output logic              done_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_e       state_q;
  logic [NR:0]  mask_q;
  logic [3:0]   rnd_q;
  logic         done_q;
  logic [127:0] store_q [NR+1];
  logic [127:0] prev_rk;
  logic [127:0] rk_next_d;
  logic [31:0]  t_w, w0, w1, w2, w3;
  logic         accept;

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign accept     = key_valid && key_ready;
  assign key_ready  = (state_q != S_EXPAND) && !abort;
  assign busy       = (state_q == S_EXPAND);
  assign keys_valid = (state_q == S_DONE);
  assign done_pulse = done_q;

  // Round r is derived from round r-1, selected without indexing past the store.
  always_comb begin
    prev_rk = '0;
    for (int i = 0; i < NR; i++) begin
      if (rnd_q == 4'(i + 1)) prev_rk = store_q[i];
    end
    t_w = sub_word({prev_rk[23:0], prev_rk[31:24]}) ^ {rcon(rnd_q), 24'h0};
    w0 = prev_rk[127:96] ^ t_w;
    w1 = prev_rk[95:64]  ^ w0;
    w2 = prev_rk[63:32]  ^ w1;
    w3 = prev_rk[31:0]   ^ w2;
    rk_next_d = {w0, w1, w2, w3};
  end

  always_comb begin
    rk_rd_data = '0;
    rk_rd_hit  = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      if (rk_rd_addr == ADDR_W'(i)) begin
        rk_rd_hit  = mask_q[i];
        rk_rd_data = store_q[i];
      end
    end
`ifdef AES_KEY_ZEROIZE_EN
    if (!rk_rd_hit) rk_rd_data = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
      for (int i = 1; i <= NR; i++) store_q[i] <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        mask_q  <= '0;
        rnd_q   <= '0;
`ifdef AES_KEY_ZEROIZE_EN
        for (int i = 1; i <= NR; i++) store_q[i] <= '0;
`endif
      end else if (accept) begin
`ifdef AES_KEY_ZEROIZE_EN
        for (int i = 1; i <= NR; i++) store_q[i] <= '0;
`endif
        store_q[0] <= key_in;
        mask_q     <= '0;
        mask_q[0]  <= 1'b1;
        rnd_q      <= 4'd1;
        state_q    <= S_EXPAND;
      end else if (state_q == S_EXPAND) begin
        for (int i = 1; i <= NR; i++) begin
          if (rnd_q == 4'(i)) begin
            store_q[i] <= rk_next_d;
            mask_q[i]  <= 1'b1;
          end
        end
        if (rnd_q == 4'(NR)) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          rnd_q   <= '0;
        end else begin
          rnd_q <= rnd_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Randomized self-checking bench for aes_key_sched_ctrl against a word-level FIPS-197 model.
// The S-box reference is derived from GF(2^8) inversion plus the affine map.
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         abort;
  logic [3:0]   rk_rd_addr;
  logic [127:0] rk_rd_data;
  logic         rk_rd_hit;
  logic         busy;
  logic         keys_valid;
  logic         done_pulse;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0]   sboxRef [256];
  logic [127:0] mRk [11];
  bit           mHave = 1'b0;
  int           mGen = 0;
  bit           mDone = 1'b0;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  always #5 clk = ~clk;

  aes_key_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .abort(abort), .rk_rd_addr(rk_rd_addr),
    .rk_rd_data(rk_rd_data), .rk_rd_hit(rk_rd_hit), .busy(busy),
    .keys_valid(keys_valid), .done_pulse(done_pulse)
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
      sboxRef[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expandKey(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sboxRef[temp[31:24]], sboxRef[temp[23:16]], sboxRef[temp[15:8]], sboxRef[temp[7:0]]};
        temp = temp ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) mRk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compareAll();
    bit expBusy;
    bit expHit;
    expBusy = mHave && (mGen < 10);
    checkOutput("busy", busy, expBusy);
    checkOutput("keysValid", keys_valid, mHave && (mGen == 10));
    checkOutput("donePulse", done_pulse, mDone);
    checkOutput("keyReady", key_ready, !expBusy && !abort);
    if (rk_rd_addr > 4'd10) begin
      checkOutput("hitOutOfRange", rk_rd_hit, 1'b0);
      checkOutput("dataOutOfRange", rk_rd_data, 128'h0);
    end else begin
      expHit = mHave && (int'(rk_rd_addr) <= mGen);
      checkOutput("hit", rk_rd_hit, expHit);
      if (expHit) checkOutput("data", rk_rd_data, mRk[rk_rd_addr]);
`ifdef AES_KEY_ZEROIZE_EN
      else checkOutput("zeroizedData", rk_rd_data, 128'h0);
`endif
    end
  endtask

  task automatic updateModel();
    if (!rst_n || abort) begin
      mHave = 1'b0; mGen = 0; mDone = 1'b0;
    end else if (key_valid && !(mHave && mGen < 10)) begin
      expandKey(key_in);
      mHave = 1'b1; mGen = 0; mDone = 1'b0;
    end else if (mHave && mGen < 10) begin
      mGen++;
      mDone = (mGen == 10);
    end else begin
      mDone = 1'b0;
    end
  endtask

  // One clock: drive, check pre-edge outputs, take the edge, advance the model.
  task automatic applyStimulus(input logic kv, input logic [127:0] k, input logic ab,
                               input logic rn, input logic [3:0] a);
    key_valid = kv; key_in = k; abort = ab; rst_n = rn; rk_rd_addr = a;
    #1;
    compareAll();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic peek(input string tag, input logic [3:0] a, input logic expHit,
                      input logic [127:0] expData);
    rk_rd_addr = a;
    #1;
    checkOutput({tag, "Hit"}, rk_rd_hit, expHit);
    if (expHit) checkOutput({tag, "Data"}, rk_rd_data, expData);
  endtask

  task automatic idle(input int n, input logic [3:0] a);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 128'h0, 1'b0, 1'b1, a);
  endtask

  initial begin
    logic [127:0] rk;
    buildSbox();
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; abort = 1'b0; rk_rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    rst_n = 1'b1;
    #1;
    checkOutput("rstKeyReady", key_ready, 1'b1);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstKeysValid", keys_valid, 1'b0);
    checkOutput("rstDone", done_pulse, 1'b0);
    checkOutput("rstHit", rk_rd_hit, 1'b0);

    // FIPS-197 key with progressive hit on entry 5
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 1'b1, 4'd5);
    for (int r = 1; r <= 10; r++) begin
      applyStimulus(1'b0, FIPS_KEY, 1'b0, 1'b1, 4'd5);
      if (r == 1) peek("fipsRk1", 4'd1, 1'b1, FIPS_RK1);
      if (r == 4) peek("addr5AfterE4", 4'd5, 1'b0, '0);
      if (r == 5) peek("addr5AfterE5", 4'd5, 1'b1, mRk[5]);
    end
    peek("fipsRk10", 4'd10, 1'b1, FIPS_RK10);
    checkOutput("fipsDonePulse", done_pulse, 1'b1);
    checkOutput("fipsKeysValid", keys_valid, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 4'd12);
    checkOutput("fipsDoneOneCycle", done_pulse, 1'b0);

    // Back-to-back all-zero key from DONE
    applyStimulus(1'b1, 128'h0, 1'b0, 1'b1, 4'd0);
    peek("zeroRk0", 4'd0, 1'b1, 128'h0);
    peek("zeroOldRk1", 4'd1, 1'b0, '0);
    idle(10, 4'd10);
    peek("zeroRk10", 4'd10, 1'b1, ZERO_RK10);

    // Abort after E6 together with key_valid
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 1'b1, 4'd0);
    idle(6, 4'd6);
    applyStimulus(1'b1, 128'h1234, 1'b1, 1'b1, 4'd3);
    checkOutput("abortBusy", busy, 1'b0);
    for (int a = 0; a < 16; a++) peek("abortNoHit", 4'(a), 1'b0, '0);
    idle(12, 4'd0);

    // Reset for one cycle after E3
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 1'b1, 4'd0);
    idle(3, 4'd2);
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 1'b0, 4'd2);
    checkOutput("midRstBusy", busy, 1'b0);
    checkOutput("midRstReady", key_ready, 1'b1);
    checkOutput("midRstHit", rk_rd_hit, 1'b0);
    idle(12, 4'd1);
    applyStimulus(1'b1, 128'hffff, 1'b0, 1'b1, 4'd0);
    peek("resendRk0", 4'd0, 1'b1, 128'hffff);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rk = '0;
      applyStimulus($urandom_range(0, 3) == 0, rk, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 79) != 0, 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
